run_seq_tx: RTL

Serial test-pattern transmitter for the consecutive-bit run detector. Loads a parallel word, serializes it MSB-first onto a single bit line with a per-bit strobe, optionally repeating it, at a rate set by a programmable clock divider. An optional built-in model predicts the detector's run flag for each emitted bit, so a board build can drive the detector and flag mismatches in hardware.

---
 rtl/run_seq_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/run_seq_tx.sv
// run_seq_tx: serial test-pattern transmitter for the consecutive-bit run detector.
// Loads a parallel word and shifts bits [L-1:0] out MSB-first, one bit every
// tick_div+1 clocks, repeating the word rep extra times with no gap between passes.
// Optional feature macro RUN_SEQ_TX_EXPECT_EN: when defined, a built-in run model
// predicts the detector flag (exp_z) for every emitted bit; when undefined, exp_z is 0.
module run_seq_tx #(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 5,
  parameter int DIV_W   = 24,
  parameter int RUN_LEN = 4
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [LEN_W-1:0]  len,
  input  logic [3:0]        rep,
  input  logic [DIV_W-1:0]  tick_div,
  output logic              w_out,
  output logic              w_valid,
  output logic              busy,
  output logic              done,
  output logic              exp_z
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_word;      // word as loaded, already MSB-aligned, for repeats
  logic [LEN_W-1:0]  r_len_m1;    // effective length minus one
  logic [LEN_W-1:0]  r_bit_cnt;
  logic [3:0]        r_rep_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;

  logic [LEN_W-1:0]  w_len_eff;
  logic [LEN_W-1:0]  w_shamt;
  logic [DATA_W-1:0] w_load;
  logic              w_tick;
  logic              w_last_bit;

  // Effective length, aligned load word and bit-period tick.
  always_comb begin
    w_len_eff = LEN_MAX;
    if ((len == LEN_W'(0)) || (len > LEN_MAX)) begin
      w_len_eff = LEN_MAX;
    end else begin
      w_len_eff = len;
    end
    w_shamt    = LEN_MAX - w_len_eff;
    w_load     = data << w_shamt;
    w_tick     = (r_state == S_SHIFT) && (r_div_cnt == r_div);
    w_last_bit = (r_bit_cnt == r_len_m1);
  end

  // Job sequencer: capture on start, shift on tick, reload for repeats, finish.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_word    <= '0;
      r_len_m1  <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= 4'd0;
      r_div     <= '0;
      r_div_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_SHIFT;
            r_shreg   <= w_load;
            r_word    <= w_load;
            r_len_m1  <= w_len_eff - LEN_W'(1);
            r_rep_cnt <= rep;
            r_div     <= tick_div;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            if (!w_last_bit) begin
              r_shreg   <= r_shreg << 1;
              r_bit_cnt <= r_bit_cnt + LEN_W'(1);
            end else if (r_rep_cnt != 4'd0) begin
              r_rep_cnt <= r_rep_cnt - 4'd1;
              r_shreg   <= r_word;
              r_bit_cnt <= '0;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_out   = (r_state == S_SHIFT) & r_shreg[DATA_W-1];
  assign w_valid = w_tick;
  assign busy    = (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);

`ifdef RUN_SEQ_TX_EXPECT_EN
  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

  logic [RUN_W-1:0] r_run;        // 0 means no bit sent yet in this job
  logic             r_last;
  logic             r_exp_z;
  logic [RUN_W-1:0] w_run_nxt;

  // Next run length: restart on first bit or on a bit change, else saturate.
  always_comb begin
    w_run_nxt = RUN_W'(1);
    if ((r_run == RUN_W'(0)) || (w_out != r_last)) begin
      w_run_nxt = RUN_W'(1);
    end else if (r_run == RUN_MAX) begin
      w_run_nxt = RUN_MAX;
    end else begin
      w_run_nxt = r_run + RUN_W'(1);
    end
  end

  // Run model state: cleared at job start, updated on each emitted bit, held otherwise.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_run   <= '0;
      r_last  <= 1'b0;
      r_exp_z <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_run   <= '0;
      r_last  <= 1'b0;
      r_exp_z <= 1'b0;
    end else if (w_tick) begin
      r_run   <= w_run_nxt;
      r_last  <= w_out;
      r_exp_z <= (w_run_nxt == RUN_MAX);
    end
  end

  assign exp_z = r_exp_z;
`else
  assign exp_z = 1'b0;
`endif

endmodule
